// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming(12,8) receive path:
// FSM encodings, syndrome function and data-bit extraction.
package hamming_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Syndromes at or above this value cannot map to a bit position.
    localparam logic [3:0] SYN_UNCORR_MIN = 4'd13;

    // syn equals the 1-based position of a single flipped bit.
    function automatic logic [3:0] syndrome(input logic [11:0] cw);
        logic g0, g1, g2, g3;
        g0 = cw[10] ^ cw[8] ^ cw[6] ^ cw[4] ^ cw[2] ^ cw[0];
        g1 = cw[10] ^ cw[9] ^ cw[6] ^ cw[5] ^ cw[2] ^ cw[1];
        g2 = cw[11] ^ cw[6] ^ cw[5] ^ cw[4] ^ cw[3];
        g3 = cw[11] ^ cw[10] ^ cw[9] ^ cw[8] ^ cw[7];
        return {g3, g2, g1, g0};
    endfunction

    // Parity lives at bits 0,1,3,7; the rest carry the byte.
    function automatic logic [7:0] extract(input logic [11:0] cw);
        return {cw[11], cw[10], cw[9], cw[8],
                cw[6], cw[5], cw[4], cw[2]};
    endfunction

endpackage

// File: rtl/hamming_rx_ctrl_decoder.sv
// Registered Hamming(12,8) corrector.
// Uncorrectable syndromes yield a zero byte.
module hamming_decoder
    import hamming_pkg::*;
(
    input  logic        clk,
    input  logic        arst,
    input  logic [11:0] data,
    output logic [7:0]  q
);

    logic [3:0]  syn;
    logic [11:0] fixed;
    logic [7:0]  d;

    // Flip the bit the syndrome points at, then pull out the byte.
    always_comb begin
        syn   = syndrome(data);
        fixed = data;
        d     = 8'h00;
        if (syn < SYN_UNCORR_MIN) begin
            for (int i = 0; i < 12; i++) begin
                if (syn == 4'(i + 1)) fixed[i] = ~data[i];
            end
            d = extract(fixed);
        end
    end

    // Output register; input is held steady by the controller.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) q <= 8'h00;
        else      q <= d;
    end

endmodule

// File: rtl/hamming_rx_ctrl.sv
// Hamming(12,8) receive controller: accept, decode, present,
// and keep saturating statistics of delivered bytes.
module hamming_rx_ctrl
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [11:0]      s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [7:0]       m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_corr,
    output logic             m_err,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_total,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_err,
    output logic             busy
);

    state_t      state_q;
    state_t      state_d;
    logic [11:0] cw_q;
    logic [3:0]  syn_q;
    logic        hs;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v,
        input logic             en
    );
        if (en && !(&v)) return v + {{(CNT_W-1){1'b0}}, 1'b1};
        return v;
    endfunction

    // Next-state and handshake outputs.
    always_comb begin
        state_d = state_q;
        s_ready = 1'b0;
        m_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                s_ready = 1'b1;
                if (s_valid) state_d = ST_DEC;
            end
            ST_DEC: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                m_valid = 1'b1;
                if (m_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Codeword capture; held until the byte leaves OUT.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)                            cw_q <= 12'h000;
        else if (state_q == ST_IDLE && s_valid) cw_q <= s_data;
    end

    // Syndrome registered in DEC so it lines up with m_data.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n)                 syn_q <= 4'h0;
        else if (state_q == ST_DEC)  syn_q <= syndrome(cw_q);
    end

    assign busy   = (state_q != ST_IDLE);
    assign hs     = m_valid && m_ready;
    assign m_corr = m_valid && (syn_q != 4'h0)
                    && (syn_q < SYN_UNCORR_MIN);
    assign m_err  = m_valid && (syn_q >= SYN_UNCORR_MIN);

    // Saturating statistics; clear wins over a handshake.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_total <= '0;
            cnt_corr  <= '0;
            cnt_err   <= '0;
        end else if (clr_cnt) begin
            cnt_total <= '0;
            cnt_corr  <= '0;
            cnt_err   <= '0;
        end else if (hs) begin
            cnt_total <= sat_inc(cnt_total, 1'b1);
            cnt_corr  <= sat_inc(cnt_corr, m_corr);
            cnt_err   <= sat_inc(cnt_err, m_err);
        end
    end

    hamming_decoder u_dec (
        .clk  (clk),
        .arst (~arst_n),
        .data (cw_q),
        .q    (m_data)
    );

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// Bench for hamming_rx_ctrl: vector table through a scoreboard,
// plus timing, backpressure, saturation, clear and reset sequences.
module tb_hamming_rx_ctrl;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [11:0] s_data;
    logic        s_valid;
    logic        m_ready;
    logic        clr_cnt;

    logic        s_ready, m_valid, m_corr, m_err, busy;
    logic [7:0]  m_data;
    logic [15:0] cnt_total, cnt_corr, cnt_err;

    logic        s_ready2, m_valid2, m_corr2, m_err2, busy2;
    logic [7:0]  m_data2;
    logic [1:0]  cnt2_total, cnt2_corr, cnt2_err;

    always #5 clk = ~clk;

    hamming_rx_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .arst_n(arst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_corr(m_corr), .m_err(m_err), .clr_cnt(clr_cnt),
        .cnt_total(cnt_total), .cnt_corr(cnt_corr),
        .cnt_err(cnt_err), .busy(busy)
    );

    hamming_rx_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .arst_n(arst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready2),
        .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready),
        .m_corr(m_corr2), .m_err(m_err2), .clr_cnt(clr_cnt),
        .cnt_total(cnt2_total), .cnt_corr(cnt2_corr),
        .cnt_err(cnt2_err), .busy(busy2)
    );

    typedef struct {
        logic [11:0] cw;
        logic [7:0]  data;
        logic        corr;
        logic        err;
    } vec_t;

    vec_t vecs[9];
    vec_t sbq[$];
    vec_t cur_exp;

    int errors = 0;
    int checks = 0;
    int pushes = 0;
    int mdl_total, mdl_corr, mdl_err;
    int mdl2_total, mdl2_corr, mdl2_err;
    int base;

    function automatic int sat(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic zero_model();
        mdl_total = 0; mdl_corr = 0; mdl_err = 0;
        mdl2_total = 0; mdl2_corr = 0; mdl2_err = 0;
    endtask

    // Sample at the falling edge what the next rising edge will do.
    task automatic monitor();
        vec_t e;
        if (arst_n && s_valid && s_ready) begin
            sbq.push_back(cur_exp);
            pushes++;
        end
        if (arst_n && m_valid && m_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_output", 32'(m_data), 32'hFFFF);
            end else begin
                e = sbq.pop_front();
                chk("m_data", 32'(m_data), 32'(e.data));
                chk("m_corr", 32'(m_corr), 32'(e.corr));
                chk("m_err", 32'(m_err), 32'(e.err));
                chk("m_data_w2", 32'(m_data2), 32'(e.data));
                chk("m_corr_w2", 32'(m_corr2), 32'(e.corr));
                chk("m_err_w2", 32'(m_err2), 32'(e.err));
                mdl_total = sat(mdl_total, 65535);
                mdl2_total = sat(mdl2_total, 3);
                if (e.corr) begin
                    mdl_corr = sat(mdl_corr, 65535);
                    mdl2_corr = sat(mdl2_corr, 3);
                end
                if (e.err) begin
                    mdl_err = sat(mdl_err, 65535);
                    mdl2_err = sat(mdl2_err, 3);
                end
            end
        end
        if (arst_n && clr_cnt) zero_model();
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_total"}, 32'(cnt_total), 32'(mdl_total));
        chk({tag, "_corr"}, 32'(cnt_corr), 32'(mdl_corr));
        chk({tag, "_err"}, 32'(cnt_err), 32'(mdl_err));
        chk({tag, "_total_w2"}, 32'(cnt2_total), 32'(mdl2_total));
        chk({tag, "_corr_w2"}, 32'(cnt2_corr), 32'(mdl2_corr));
        chk({tag, "_err_w2"}, 32'(cnt2_err), 32'(mdl2_err));
    endtask

    task automatic send(input vec_t v);
        int n;
        int p0;
        cur_exp = v;
        s_data  = v.cw;
        s_valid = 1'b1;
        m_ready = 1'b1;
        p0 = pushes;
        n = 0;
        while (pushes == p0 && n < 10) begin
            tick();
            n++;
        end
        if (pushes == p0) chk("accept_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (sbq.size() != 0) chk("output_timeout", 32'd0, 32'd1);
        chk_cnt("cnt");
    endtask

    initial begin
        vecs[0] = '{12'hA27, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{12'hA07, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{12'hA26, 8'hA5, 1'b1, 1'b0};
        vecs[3] = '{12'h226, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{12'hF77, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{12'h777, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{12'h040, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{12'h225, 8'h00, 1'b0, 1'b1};
        vecs[8] = '{12'h223, 8'h00, 1'b0, 1'b1};

        zero_model();
        cur_exp = vecs[0];
        arst_n  = 1'b0;
        s_valid = 1'b0;
        s_data  = 12'h000;
        m_ready = 1'b0;
        clr_cnt = 1'b0;

        #12;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'h00);
        chk("rst_m_corr", 32'(m_corr), 32'd0);
        chk("rst_m_err", 32'(m_err), 32'd0);
        chk("rst_m_valid_w2", 32'(m_valid2), 32'd0);
        chk("rst_busy_w2", 32'(busy2), 32'd0);
        chk_cnt("rst_cnt");
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("s_ready_after_rst", 32'(s_ready), 32'd1);
        chk("s_ready_after_rst_w2", 32'(s_ready2), 32'd1);

        // Latency and backpressure on a clean codeword.
        cur_exp = vecs[0];
        s_data  = vecs[0].cw;
        s_valid = 1'b1;
        m_ready = 1'b0;
        tick();
        chk("lat_dec_m_valid", 32'(m_valid), 32'd0);
        chk("lat_dec_s_ready", 32'(s_ready), 32'd0);
        chk("lat_dec_busy", 32'(busy), 32'd1);
        s_data = 12'h226;
        tick();
        chk("lat_out_m_valid", 32'(m_valid), 32'd1);
        chk("lat_out_m_data", 32'(m_data), 32'hA5);
        chk("lat_out_m_corr", 32'(m_corr), 32'd0);
        chk("lat_out_m_err", 32'(m_err), 32'd0);
        base = mdl_total;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_m_data", 32'(m_data), 32'hA5);
            chk("bp_m_valid", 32'(m_valid), 32'd1);
            chk("bp_s_ready", 32'(s_ready), 32'd0);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        chk("bp_cnt_total", 32'(cnt_total), 32'(base + 1));
        tick();
        tick();
        chk("bp_cnt_once", 32'(cnt_total), 32'(base + 1));
        chk("bp_idle_m_valid", 32'(m_valid), 32'd0);
        chk("bp_queue_empty", 32'(sbq.size()), 32'd0);

        // Table of codewords, each through the scoreboard.
        for (int i = 0; i < 9; i++) send(vecs[i]);
        chk("sat_w2_total", 32'(cnt2_total), 32'd3);
        chk("full_total", 32'(cnt_total), 32'd10);
        chk("full_corr", 32'(cnt_corr), 32'd4);
        chk("full_err", 32'(cnt_err), 32'd3);

        // Reset pulse while in DEC drops the codeword.
        cur_exp = vecs[1];
        s_data  = vecs[1].cw;
        s_valid = 1'b1;
        m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        arst_n = 1'b0;
        #1;
        sbq.delete();
        zero_model();
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_m_data", 32'(m_data), 32'h00);
        chk_cnt("mid_rst_cnt");
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);
        tick();
        tick();
        tick();
        chk("post_rst_m_valid", 32'(m_valid), 32'd0);
        chk_cnt("post_rst_cnt");

        send(vecs[3]);
        send(vecs[1]);

        // Clear coinciding with a handshake.
        cur_exp = vecs[5];
        s_data  = vecs[5].cw;
        s_valid = 1'b1;
        m_ready = 1'b0;
        tick();
        s_valid = 1'b0;
        tick();
        chk("clr_pre_m_valid", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_total", 32'(cnt_total), 32'd0);
        chk("clr_corr", 32'(cnt_corr), 32'd0);
        chk("clr_err", 32'(cnt_err), 32'd0);
        chk_cnt("clr_cnt");

        send(vecs[2]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
